// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters. Arbitration is round-robin,
// a packet owner is locked until its last byte, and an idle owner loses the lock after a timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned MIN_GAP = 2
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    input  logic              uart_tx_ready,
    output logic              uart_tx_start,
    output logic [7:0]        uart_tx_data_in,
    output logic [2:0]        grant_id,
    output logic              locked,
    output logic              timeout
);
    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [TO_W-1:0]  idle_cnt, idle_cnt_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [IDX_W-1:0] owner, owner_d;
    logic             locked_d;
    logic             timeout_d;
    logic             start_d;
    logic [NREQ-1:0]  ack_d;
    logic [7:0]       data_d;
    logic [2:0]       gid_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic [IDX_W:0]   cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Candidate selection: the owner when locked, else first requester at or after ptr.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        if (locked) begin
            sel_idx   = owner;
            sel_valid = req[owner];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NREQ)) begin
                    cand = cand - (IDX_W+1)'(NREQ);
                end
                if (req[cand[IDX_W-1:0]]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        gap_cnt_d  = gap_cnt;
        idle_cnt_d = idle_cnt;
        ptr_d      = ptr;
        owner_d    = owner;
        locked_d   = locked;
        timeout_d  = 1'b0;
        start_d    = 1'b0;
        ack_d      = '0;
        data_d     = uart_tx_data_in;
        gid_d      = grant_id;

        case (state)
            IDLE: begin
                if (sel_valid && uart_tx_ready) begin
                    start_d    = 1'b1;
                    ack_d      = NREQ'(1) << sel_idx;
                    data_d     = sel_data;
                    gid_d      = 3'(sel_idx);
                    state_d    = GAP;
                    gap_cnt_d  = '0;
                    idle_cnt_d = '0;
                    if (req_last[sel_idx]) begin
                        locked_d = 1'b0;
                        ptr_d    = next_idx(sel_idx);
                    end else begin
                        locked_d = 1'b1;
                        owner_d  = sel_idx;
                    end
                end else if (locked && !req[owner]) begin
                    // Owner is idle mid-packet; revoke the lock once the budget is spent.
                    if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        locked_d   = 1'b0;
                        timeout_d  = 1'b1;
                        ptr_d      = next_idx(owner);
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt + TO_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(MIN_GAP - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            idle_cnt        <= '0;
            ptr             <= '0;
            owner           <= '0;
            locked          <= 1'b0;
            timeout         <= 1'b0;
            uart_tx_start   <= 1'b0;
            req_ack         <= '0;
            uart_tx_data_in <= 8'h00;
            grant_id        <= 3'd0;
        end else begin
            state           <= state_d;
            gap_cnt         <= gap_cnt_d;
            idle_cnt        <= idle_cnt_d;
            ptr             <= ptr_d;
            owner           <= owner_d;
            locked          <= locked_d;
            timeout         <= timeout_d;
            uart_tx_start   <= start_d;
            req_ack         <= ack_d;
            uart_tx_data_in <= data_d;
            grant_id        <= gid_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: vector table, directed corner sequences and
// randomized traffic checked every cycle against a cycle-stamped reference model.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int MIN_GAP = 2;

    logic        pll_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic        uart_tx_ready;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data_in;
    logic [2:0]  grant_id;
    logic        locked;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MIN_GAP(MIN_GAP)) dut (
        .pll_clk        (pll_clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ack        (req_ack),
        .uart_tx_ready  (uart_tx_ready),
        .uart_tx_start  (uart_tx_start),
        .uart_tx_data_in(uart_tx_data_in),
        .grant_id       (grant_id),
        .locked         (locked),
        .timeout        (timeout)
    );

    always #5 pll_clk = ~pll_clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pll_clk);
        #2;
    endtask

    // Reference model: timestamps instead of a state machine; the byte granted at
    // edge e is strobed after e, and arbitration resumes MIN_GAP cycles later.
    int         m_edge     = 0;
    int         m_next_arb = 0;
    int         m_idle     = 0;
    int         m_owner    = 0;
    int         m_ptr      = 0;
    bit         m_valid    = 1'b0;
    bit         m_locked   = 1'b0;
    logic       e_start    = 1'b0;
    logic       e_to       = 1'b0;
    logic [3:0] e_ack      = 4'h0;
    logic [7:0] e_data     = 8'h00;
    logic [2:0] e_gid      = 3'd0;

    always @(posedge pll_clk) begin
        logic [3:0]  s_req;
        logic [3:0]  s_last;
        logic [31:0] s_data;
        logic        s_rdy;
        logic        s_rst;
        int          pick;
        s_req  = req;
        s_last = req_last;
        s_data = req_data;
        s_rdy  = uart_tx_ready;
        s_rst  = rst_n;
        e_start = 1'b0;
        e_ack   = 4'h0;
        e_to    = 1'b0;
        if (!s_rst) begin
            m_valid    = 1'b1;
            m_next_arb = m_edge + 1;
            m_locked   = 1'b0;
            m_idle     = 0;
            m_ptr      = 0;
            m_owner    = 0;
            e_data     = 8'h00;
            e_gid      = 3'd0;
        end else if (m_edge >= m_next_arb) begin
            pick = -1;
            if (m_locked) begin
                if (s_req[m_owner]) pick = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (pick < 0 && s_req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
                end
            end
            if (pick >= 0 && s_rdy) begin
                e_start     = 1'b1;
                e_ack[pick] = 1'b1;
                e_data      = s_data[8*pick +: 8];
                e_gid       = 3'(pick);
                m_next_arb  = m_edge + 1 + MIN_GAP;
                m_idle      = 0;
                if (s_last[pick]) begin
                    m_locked = 1'b0;
                    m_ptr    = (pick + 1) % NREQ;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = pick;
                end
            end else if (m_locked && !s_req[m_owner]) begin
                if (m_idle == TIMEOUT - 1) begin
                    m_locked = 1'b0;
                    e_to     = 1'b1;
                    m_ptr    = (m_owner + 1) % NREQ;
                    m_idle   = 0;
                end else begin
                    m_idle++;
                end
            end
        end
        m_edge++;
        #1;
        if (m_valid) begin
            check("model_start",  m_edge, 32'(uart_tx_start),   32'(e_start));
            check("model_ack",    m_edge, 32'(req_ack),         32'(e_ack));
            check("model_data",   m_edge, 32'(uart_tx_data_in), 32'(e_data));
            check("model_gid",    m_edge, 32'(grant_id),        32'(e_gid));
            check("model_locked", m_edge, 32'(locked),          32'(m_locked));
            check("model_timeout",m_edge, 32'(timeout),         32'(e_to));
        end
    end

    // Requester behaviour: hold head byte until acked, pop it in the cycle after the ack.
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    byte_t    q [4][$];
    bit [3:0] presenting;
    bit [3:0] pend_pop;
    int       stall [4];
    bit       rnd_mode;

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            stall[i] = 0;
        end
        presenting = '0;
        pend_pop   = '0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (pend_pop[i]) begin
                if (q[i].size() > 0) q[i].delete(0);
                pend_pop[i]   = 1'b0;
                presenting[i] = 1'b0;
                stall[i] = (rnd_mode && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 0;
            end
            if (req_ack[i] && presenting[i]) pend_pop[i] = 1'b1;
            if (!presenting[i]) begin
                if (stall[i] > 0) stall[i]--;
                else if (q[i].size() > 0) presenting[i] = 1'b1;
            end
            req[i] = presenting[i];
            if (presenting[i]) begin
                req_data[8*i +: 8] = q[i][0].d;
                req_last[i]        = q[i][0].l;
            end
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req           = 4'h0;
        req_last      = 4'h0;
        req_data      = 32'h0;
        uart_tx_ready = 1'b1;
        clear_reqs();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        e_start;
        logic [3:0]  e_ack;
        logic [7:0]  e_data;
        logic [2:0]  e_gid;
        logic        e_locked;
        logic        e_to;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] d,
                                input logic [3:0] l, input logic rdy, input logic st,
                                input logic [3:0] ak, input logic [7:0] ed, input logic [2:0] g,
                                input logic lk, input logic to);
        vec_t v;
        v.rst_n = r;  v.req = rq;     v.data = d;    v.last = l;   v.rdy = rdy;
        v.e_start = st; v.e_ack = ak; v.e_data = ed; v.e_gid = g;  v.e_locked = lk; v.e_to = to;
        return v;
    endfunction

    initial begin
        vec_t  tbl[$];
        int    gids[$];
        int    times[$];
        int    cyc;
        int    exp_g[5] = '{1, 1, 1, 3, 0};
        int    exp_t[5] = '{1, 4, 7, 10, 13};
        byte_t b;

        rst_n = 1'b0; req = 4'h0; req_last = 4'h0; req_data = 32'h0; uart_tx_ready = 1'b1;
        rnd_mode = 1'b0;
        clear_reqs();

        // Single byte from requester 2, then a second byte after the gap.
        tbl.push_back(mk(0, 4'h0, 32'h0,         4'h0, 1, 0, 4'h0, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h0041_0000, 4'h4, 1, 1, 4'h4, 8'h41, 3'd2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h0041_0000, 4'h4, 1, 0, 4'h0, 8'h41, 3'd2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h0042_0000, 4'h4, 1, 0, 4'h0, 8'h41, 3'd2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h0042_0000, 4'h4, 1, 1, 4'h4, 8'h42, 3'd2, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h0042_0000, 4'h4, 1, 0, 4'h0, 8'h42, 3'd2, 0, 0));
        tbl.push_back(mk(1, 4'h0, 32'h0,         4'h0, 1, 0, 4'h0, 8'h42, 3'd2, 0, 0));
        // Round-robin with all four requesting single-byte packets.
        tbl.push_back(mk(0, 4'h0, 32'h0,         4'h0, 1, 0, 4'h0, 8'h00, 3'd0, 0, 0));
        for (int k = 0; k < 14; k++) begin
            int g;
            g = (k / 3) % 4;
            tbl.push_back(mk(1, 4'hF, 32'h1312_1110, 4'hF, 1, (k % 3) == 0,
                             ((k % 3) == 0) ? 4'(1 << g) : 4'h0, 8'(16 + g), 3'(g), 0, 0));
        end

        for (int r = 0; r < tbl.size(); r++) begin
            rst_n = tbl[r].rst_n; req = tbl[r].req; req_data = tbl[r].data;
            req_last = tbl[r].last; uart_tx_ready = tbl[r].rdy;
            step();
            check("tbl_start",   r, 32'(uart_tx_start),   32'(tbl[r].e_start));
            check("tbl_ack",     r, 32'(req_ack),         32'(tbl[r].e_ack));
            check("tbl_data",    r, 32'(uart_tx_data_in), 32'(tbl[r].e_data));
            check("tbl_gid",     r, 32'(grant_id),        32'(tbl[r].e_gid));
            check("tbl_locked",  r, 32'(locked),          32'(tbl[r].e_locked));
            check("tbl_timeout", r, 32'(timeout),         32'(tbl[r].e_to));
        end

        // Packet lock: requester 1 sends three bytes while 0 and 3 wait.
        do_reset();
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            b.d = 8'(8'hC1 + i); b.l = (i == 2); q[1].push_back(b);
        end
        for (int n = 0; n < 18; n++) begin
            if (n == 1) begin
                b.d = 8'hD0; b.l = 1'b1; q[0].push_back(b);
                b.d = 8'hD3; b.l = 1'b1; q[3].push_back(b);
            end
            drive_reqs();
            step();
            cyc++;
            if (uart_tx_start) begin
                gids.push_back(int'(grant_id));
                times.push_back(cyc);
            end
        end
        check("lock_count", 0, 32'(gids.size()), 5);
        for (int i = 0; i < 5 && i < gids.size(); i++) begin
            check("lock_gid",   i, 32'(gids[i]),  32'(exp_g[i]));
            check("lock_cycle", i, 32'(times[i]), 32'(exp_t[i]));
        end

        // Timeout: owner 0 goes idle after a non-final byte, requester 1 waits.
        do_reset();
        req = 4'b0011; req_data = 32'h0000_B1A0; req_last = 4'b0010;
        step();
        check("to_first_start", 1, 32'(uart_tx_start), 1);
        check("to_first_gid",   1, 32'(grant_id), 0);
        check("to_lock_set",    1, 32'(locked), 1);
        step();
        req = 4'b0010;
        for (int c = 3; c <= 10; c++) begin
            step();
            check("to_wait_locked", c, 32'(locked), 1);
            check("to_wait_pulse",  c, 32'(timeout), 0);
        end
        step();
        check("to_pulse",    11, 32'(timeout), 1);
        check("to_unlocked", 11, 32'(locked), 0);
        check("to_no_start", 11, 32'(uart_tx_start), 0);
        step();
        check("to_next_start", 12, 32'(uart_tx_start), 1);
        check("to_next_gid",   12, 32'(grant_id), 1);
        check("to_next_data",  12, 32'(uart_tx_data_in), 'hB1);
        check("to_pulse_end",  12, 32'(timeout), 0);
        step();
        req = 4'h0;
        step();

        // Backpressure: ready low for 20 cycles.
        do_reset();
        req = 4'b0001; req_data = 32'h0000_005A; req_last = 4'b0001; uart_tx_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            check("bp_no_start", c, 32'(uart_tx_start), 0);
            check("bp_no_ack",   c, 32'(req_ack), 0);
        end
        uart_tx_ready = 1'b1;
        step();
        check("bp_start", 21, 32'(uart_tx_start), 1);
        check("bp_ack",   21, 32'(req_ack), 1);
        check("bp_data",  21, 32'(uart_tx_data_in), 'h5A);
        step();
        req = 4'h0;
        step();

        // Reset while locked and in the gap.
        do_reset();
        req = 4'b0001; req_data = 32'h0000_0077; req_last = 4'b0000;
        step();
        check("rst_pre_locked", 1, 32'(locked), 1);
        rst_n = 1'b0; req = 4'b1010; req_data = 32'h3300_1100; req_last = 4'b1010;
        step();
        check("rst_start",   2, 32'(uart_tx_start), 0);
        check("rst_ack",     2, 32'(req_ack), 0);
        check("rst_data",    2, 32'(uart_tx_data_in), 0);
        check("rst_gid",     2, 32'(grant_id), 0);
        check("rst_locked",  2, 32'(locked), 0);
        check("rst_timeout", 2, 32'(timeout), 0);
        rst_n = 1'b1;
        step();
        check("rst_after_start", 3, 32'(uart_tx_start), 1);
        check("rst_after_gid",   3, 32'(grant_id), 1);
        check("rst_after_data",  3, 32'(uart_tx_data_in), 'h11);
        check("rst_after_ack",   3, 32'(req_ack), 'h2);
        step();
        req = 4'h0;
        step();

        // Randomized traffic: packets, stalls, backpressure and occasional resets.
        do_reset();
        rnd_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 5) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int j = 0; j < len; j++) begin
                        b.d = 8'($urandom);
                        b.l = (j == len - 1);
                        q[i].push_back(b);
                    end
                end
            end
            rst_n         = ($urandom_range(0, 399) != 0);
            uart_tx_ready = ($urandom_range(0, 4) != 0);
            drive_reqs();
            step();
        end
        rst_n = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters, with a range of 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, giving the pll_clk cycles a locked owner may idle before its lock is revoked.
REQ-003 The block SHALL have parameter MIN_GAP, default 2, giving the idle cycles after each issued byte, with a minimum of 1.
REQ-004 The block SHALL have port pll_clk, input, 1 bit: the clock, with all state updating on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester byte request, held high until the matching ack.
REQ-007 The block SHALL have port req_data, input, 8*NREQ bits: byte i at bits [8i+7:8i], held stable while req[i] is high.
REQ-008 The block SHALL have port req_last, input, NREQ bits: marks byte i as the final byte of its packet.
REQ-009 The block SHALL have port req_ack, output, NREQ bits: a one-cycle pulse when byte i is taken.
REQ-010 The block SHALL have port uart_tx_ready, input, 1 bit: high when the UART transmitter can accept a byte.
REQ-011 The block SHALL have port uart_tx_start, output, 1 bit: the one-cycle write strobe to the UART.
REQ-012 The block SHALL have port uart_tx_data_in, output, 8 bits: the byte presented with uart_tx_start.
REQ-013 The block SHALL have port grant_id, output, 3 bits: the index of the last granted requester.
REQ-014 The block SHALL have port locked, output, 1 bit: high while a packet owner holds the UART.
REQ-015 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when a lock is revoked.

Function
REQ-016 The block SHALL implement a state machine with two states: IDLE (arbitrate) and GAP (count MIN_GAP cycles, then return to IDLE).
REQ-017 In IDLE, when unlocked, the block SHALL consider requesters ptr, ptr+1, ... modulo NREQ and select the first one with req high.
REQ-018 In IDLE, when locked, the block SHALL consider only the owner, with other requests ignored however long they are held.
REQ-019 A grant SHALL occur only in IDLE, only when the selected req is high and uart_tx_ready=1; otherwise the block SHALL remain in IDLE with no outputs pulsed.
REQ-020 On a grant, at the next edge the block SHALL set uart_tx_start=1, uart_tx_data_in=req_data[i], req_ack[i]=1 and grant_id=i, and enter GAP; the latency from request-visible to strobe SHALL be 1 cycle.
REQ-021 uart_tx_start and req_ack SHALL be high for exactly one cycle per byte, and SHALL be low throughout GAP.
REQ-022 uart_tx_data_in SHALL hold its last value when not strobing.
REQ-023 If the granted byte has req_last=0, the block SHALL set locked=1 and owner=i.
REQ-024 If the granted byte has req_last=1, the block SHALL clear locked and set ptr=(i+1) modulo NREQ, wrapping from NREQ-1 to 0.
REQ-025 Requests SHALL NOT be sampled during GAP, so a requester updates req/data in the cycle after its ack without causing a stale regrant.
REQ-026 While locked in IDLE with req[owner]=0, a cycle counter SHALL increment; it SHALL clear on any grant and on leaving the locked state.
REQ-027 When the counter reaches TIMEOUT-1, at the next edge the block SHALL clear locked, pulse timeout for one cycle, set ptr=(owner+1) modulo NREQ, and clear the counter.
REQ-028 If the owner raises req in the same cycle the counter reaches TIMEOUT-1, the grant SHALL win and no timeout SHALL occur.
REQ-029 If uart_tx_ready drops while the owner is waiting, the counter SHALL NOT advance if req[owner]=1.
REQ-030 The counter width SHALL be ceil(log2(TIMEOUT+1)), and the gap counter width SHALL be ceil(log2(MIN_GAP+1)); neither SHALL overflow.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL return to IDLE with uart_tx_start=0, uart_tx_data_in=0, req_ack=0, grant_id=0, locked=0, timeout=0, ptr=0 and all counters 0.
REQ-032 A reset asserted mid-packet or during GAP SHALL abandon the lock with no further strobe, and arbitration SHALL restart from requester 0.

Verification
REQ-033 The bench SHALL cover a single byte: req[2]=1, data 0x41, last=1, ready=1 -> one cycle later start=1, data_in=0x41, ack[2]=1, grant_id=2; no second strobe for MIN_GAP cycles.
REQ-034 The bench SHALL cover round-robin: req=4'b1111 held, all last=1 -> grants in order 0,1,2,3,0, each followed by MIN_GAP idle cycles.
REQ-035 The bench SHALL cover a packet lock: req[1] sends 3 bytes with last on the 3rd while req[0] and req[3] are held -> bytes 1,1,1 are strictly consecutive, then grant 3, then grant 0.
REQ-036 The bench SHALL cover timeout: requester 0 sends a byte with last=0, then drops req; TIMEOUT=8 -> timeout pulses 8 cycles after the GAP ends, locked=0, and a pending req[1] is granted next.
REQ-037 The bench SHALL cover backpressure: ready=0 for 20 cycles with req[0]=1 -> no strobe and no ack; ready=1 -> strobe on the following edge.
REQ-038 The bench SHALL cover mid-operation reset: rst_n=0 for 1 cycle while locked -> all outputs reach their reset values; afterwards, with req=4'b1010, requester 1 is granted first.
